// File: rtl/ir_prefetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction prefetch queue.
// The master drives fetch words and decode control; the slave is the queue.
interface ir_prefetch_queue_if #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 4,
   parameter int OPCODE_W = 7,
   parameter int OP_W     = 3
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]    in;
   logic                inValid;
   logic                inReady;
   logic                take;
   logic                flush;
   logic                outValid;
   logic [OPCODE_W-1:0] outOpcode;
   logic [OP_W-1:0]     outOp0;
   logic [OP_W-1:0]     outOp1;
   logic [OP_W-1:0]     outOp2;
   logic [CW-1:0]       count;

   modport master (
      output in, inValid, take, flush,
      input  inReady, outValid, outOpcode, outOp0, outOp1, outOp2, count
   );

   modport slave (
      input  in, inValid, take, flush,
      output inReady, outValid, outOpcode, outOp0, outOp1, outOp2, count
   );
endinterface

// File: rtl/ir_prefetch_queue.sv
// Instruction prefetch FIFO: fetched words queue up and the oldest one is
// presented to decode already split into opcode and three operand fields.
module ir_prefetch_queue #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 4,
   parameter int OPCODE_W = 7,
   parameter int OP_W     = 3
) (
   input logic               clock,
   input logic               reset,
   ir_prefetch_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   if (WIDTH != OPCODE_W + 3 * OP_W) begin : gBadWidth
      $error("ir_prefetch_queue: WIDTH must equal OPCODE_W + 3*OP_W");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
      $error("ir_prefetch_queue: DEPTH must be a power of two >= 2");
   end

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PW-1:0]               wptr, rptr;
   logic [CW-1:0]               cnt;
   logic                        push, pop;
   logic [WIDTH-1:0]            head;

   // Ready comes from registered occupancy only, so a same-cycle take
   // never opens a slot for a full queue.
   assign bus.inReady  = cnt < CW'(DEPTH);
   assign bus.outValid = cnt != '0;
   assign bus.count    = cnt;
   assign push         = bus.inValid && bus.inReady;
   assign pop          = bus.take && bus.outValid;

   // Pointers are exactly log2(DEPTH) bits, so increment wraps for free.
   always_ff @(posedge clock) begin
      if (reset || bus.flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= bus.in;
            wptr      <= wptr + 1'b1;
         end
         if (pop)
            rptr <= rptr + 1'b1;
         if (push && !pop)
            cnt <= cnt + 1'b1;
         else if (pop && !push)
            cnt <= cnt - 1'b1;
      end
   end

   assign head          = bus.outValid ? mem[rptr] : '0;
   assign bus.outOpcode = head[WIDTH-1 -: OPCODE_W];
   assign bus.outOp0    = head[2*OP_W +: OP_W];
   assign bus.outOp1    = head[OP_W +: OP_W];
   assign bus.outOp2    = head[0 +: OP_W];
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a queue model.
module tb_ir_prefetch_queue;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   started = 1'b0;
   logic [15:0] q[$];

   ir_prefetch_queue_if #(.WIDTH(16), .DEPTH(DEPTH), .OPCODE_W(7), .OP_W(3)) bus ();

   ir_prefetch_queue #(.WIDTH(16), .DEPTH(DEPTH), .OPCODE_W(7), .OP_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a plain queue of words with the occupancy rules applied.
   always @(posedge clock) begin
      if (reset || bus.flush) begin
         q.delete();
      end else begin
         bit pu, po;
         pu = bus.inValid && (q.size() < DEPTH);
         po = bus.take && (q.size() > 0);
         if (po) void'(q.pop_front());
         if (pu) q.push_back(bus.in);
      end
   end

   always @(negedge clock) begin
      if (started) begin
         logic [15:0] w;
         w = (q.size() != 0) ? q[0] : 16'h0;
         chk("m_outValid", 32'(bus.outValid), 32'(q.size() != 0));
         chk("m_count",    32'(bus.count),    32'(q.size()));
         chk("m_inReady",  32'(bus.inReady),  32'(q.size() < DEPTH));
         chk("m_opcode",   32'(bus.outOpcode), 32'(w >> 9));
         chk("m_op0",      32'(bus.outOp0),   32'((w >> 6) & 16'h7));
         chk("m_op1",      32'(bus.outOp1),   32'((w >> 3) & 16'h7));
         chk("m_op2",      32'(bus.outOp2),   32'(w & 16'h7));
      end
   end

   function automatic logic [15:0] headWord();
      return {bus.outOpcode, bus.outOp0, bus.outOp1, bus.outOp2};
   endfunction

   // Apply one cycle of inputs; returns 1 time unit after the edge.
   task automatic cyc(input logic iv, input logic [15:0] d, input logic tk,
                      input logic fl, input logic rs);
      bus.inValid = iv;
      bus.in      = d;
      bus.take    = tk;
      bus.flush   = fl;
      reset       = rs;
      @(posedge clock);
      #1;
      bus.inValid = 1'b0;
      bus.take    = 1'b0;
      bus.flush   = 1'b0;
      reset       = 1'b0;
   endtask

   initial begin
      bus.in = '0; bus.inValid = 1'b0; bus.take = 1'b0; bus.flush = 1'b0;
      cyc(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b1);
      started = 1'b1;
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("rst_inReady", 32'(bus.inReady), 1);
      chk("rst_outValid", 32'(bus.outValid), 0);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_fields", 32'(headWord()), 0);

      // Single word split
      cyc(1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0);
      chk("a5c3_valid", 32'(bus.outValid), 1);
      chk("a5c3_opcode", 32'(bus.outOpcode), 32'h52);
      chk("a5c3_op0", 32'(bus.outOp0), 7);
      chk("a5c3_op1", 32'(bus.outOp1), 0);
      chk("a5c3_op2", 32'(bus.outOp2), 3);
      chk("a5c3_count", 32'(bus.count), 1);
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      chk("a5c3_taken_valid", 32'(bus.outValid), 0);
      chk("a5c3_taken_fields", 32'(headWord()), 0);

      // Fill to full, rejected fifth push, ordered drain
      for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      chk("full_count", 32'(bus.count), 4);
      chk("full_inReady", 32'(bus.inReady), 0);
      cyc(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
      chk("full_reject_count", 32'(bus.count), 4);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_order", 32'(headWord()), i);
         cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      end
      chk("drain_empty", 32'(bus.outValid), 0);

      // Sustained push+pop through several pointer wraps
      cyc(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 16'(16'h0101 + i), 1'b1, 1'b0, 1'b0);
         chk("stream_count", 32'(bus.count), 1);
         chk("stream_head", 32'(headWord()), 32'(16'h0101 + i));
      end
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

      // Flush overrides concurrent push and pop
      for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
      chk("preflush_count", 32'(bus.count), 3);
      cyc(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
      chk("flush_count", 32'(bus.count), 0);
      chk("flush_valid", 32'(bus.outValid), 0);
      chk("flush_ready", 32'(bus.inReady), 1);
      cyc(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
      chk("postflush_opcode", 32'(bus.outOpcode), 0);
      chk("postflush_op0", 32'(bus.outOp0), 1);
      chk("postflush_op1", 32'(bus.outOp1), 0);
      chk("postflush_op2", 32'(bus.outOp2), 0);
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

      // Takes on an empty queue must not move anything
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
         chk("empty_take_count", 32'(bus.count), 0);
      end
      cyc(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      chk("ffff_opcode", 32'(bus.outOpcode), 32'h7F);
      chk("ffff_op0", 32'(bus.outOp0), 7);
      chk("ffff_op1", 32'(bus.outOp1), 7);
      chk("ffff_op2", 32'(bus.outOp2), 7);
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

      // Push with simultaneous take on empty queue enqueues only
      cyc(1'b1, 16'h0303, 1'b1, 1'b0, 1'b0);
      chk("empty_pushtake_count", 32'(bus.count), 1);
      chk("empty_pushtake_head", 32'(headWord()), 32'h0303);

      // Mid-operation reset while pushing
      cyc(1'b1, 16'h0304, 1'b0, 1'b0, 1'b0);
      chk("prereset_count", 32'(bus.count), 2);
      cyc(1'b1, 16'h0305, 1'b0, 1'b0, 1'b1);
      chk("midreset_count", 32'(bus.count), 0);
      chk("midreset_valid", 32'(bus.outValid), 0);
      chk("midreset_ready", 32'(bus.inReady), 1);
      chk("midreset_fields", 32'(headWord()), 0);

      // Random traffic, checked by the per-cycle model compare
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
             $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
      end

      @(negedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
